tile_plot_decoder: RTL

Receive-side counterpart of the tile bitmap renderer: watches the `x`/`y`/`colour`/`plot` pixel stream that feeds `vga_adapter` and rebuilds the 16×16 tile bitmap it encodes. Tiles sit on a 10-pixel horizontal and 7-pixel vertical pitch, with each tile drawn as an 8×8 block. The block sits in parallel with `vga_adapter` on the same bus. It gives the bench and the game logic a readable copy of what was drawn, plus a frame-complete pulse.

---
 rtl/tile_pkg.sv | 16 +
 rtl/tile_plot_decoder_if.sv | 27 ++
 rtl/tile_origin_match.sv | 37 +++
 rtl/tile_plot_decoder.sv | 93 +++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared tile-grid geometry used by the renderer and the plot decoder.
// Keep both ends on this package so their pitch and screen bounds always agree.
package tile_pkg;

  localparam int unsigned TILE_PITCH_X = 10;
  localparam int unsigned TILE_PITCH_Y = 7;
  localparam int unsigned TILE_SIZE    = 8;
  localparam int unsigned GRID_DIM     = 16;
  localparam int unsigned SCREEN_W     = 160;
  localparam int unsigned SCREEN_H     = 120;

  localparam logic [2:0] FG_COLOUR_DEFAULT = 3'b110;

  typedef logic [GRID_DIM-1:0] row_t;

endpackage

// File: rtl/tile_plot_decoder_if.sv
// Pixel-stream tap plus bitmap read port of the tile plot decoder.
// The master drives plots, clear and read requests; the slave (the decoder) returns read data and status.
interface tile_plot_decoder_if;

  logic        clear;
  logic        plot;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        rd_req;
  logic [3:0]  rd_row;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        frame_done;
  logic        oob_err;

  modport master (
    output clear, plot, x, y, colour, rd_req, rd_row,
    input  rd_valid, rd_data, frame_done, oob_err
  );

  modport slave (
    input  clear, plot, x, y, colour, rd_req, rd_row,
    output rd_valid, rd_data, frame_done, oob_err
  );

endinterface

// File: rtl/tile_origin_match.sv
// Combinational tile-origin detector: compares x/y against the 16 pitch multiples per axis.
// Zero latency; no state, no backpressure.
module tile_origin_match
  import tile_pkg::*;
(
  input  logic [7:0] x,
  input  logic [6:0] y,
  output logic       is_origin,
  output logic [3:0] col,
  output logic [3:0] row,
  output logic       in_range
);

  logic w_x_hit;
  logic w_y_hit;

  always_comb begin
    w_x_hit = 1'b0;
    w_y_hit = 1'b0;
    col     = 4'd0;
    row     = 4'd0;
    for (int i = 0; i < int'(GRID_DIM); i++) begin
      if (x == 8'(i * TILE_PITCH_X)) begin
        w_x_hit = 1'b1;
        col     = 4'(i);
      end
      if (y == 7'(i * TILE_PITCH_Y)) begin
        w_y_hit = 1'b1;
        row     = 4'(i);
      end
    end
  end

  assign in_range  = (x < 8'(SCREEN_W)) && (y < 7'(SCREEN_H));
  assign is_origin = w_x_hit && w_y_hit;

endmodule

// File: rtl/tile_plot_decoder.sv
// Rebuilds the 16x16 tile bitmap from the vga pixel stream; 1-cycle registered row reads.
// Accepts one plot per cycle with no backpressure; frame_done pulses on the last plot of a frame.
module tile_plot_decoder
  import tile_pkg::*;
#(
  parameter logic [2:0] FG_COLOUR       = FG_COLOUR_DEFAULT,
  parameter int         PLOTS_PER_FRAME = 16384
) (
  input  logic                fastclock,
  input  logic                resetn,
  tile_plot_decoder_if.slave  bus
);

  localparam logic [13:0] LAST_PLOT = 14'(PLOTS_PER_FRAME - 1);

  row_t        r_bitmap [GRID_DIM];
  logic [13:0] r_cnt;
  logic        r_rd_valid;
  row_t        r_rd_data;
  logic        r_frame_done;
  logic        r_oob_err;

  logic        w_is_origin;
  logic [3:0]  w_col;
  logic [3:0]  w_row;
  logic        w_in_range;
  logic        w_accept;

  tile_origin_match u_match (
    .x         (bus.x),
    .y         (bus.y),
    .is_origin (w_is_origin),
    .col       (w_col),
    .row       (w_row),
    .in_range  (w_in_range)
  );

  assign w_accept = bus.plot && w_in_range && !bus.clear;

  // Column 0 is the MSB, so bit index 15-col is simply the inverted column.
  always_ff @(posedge fastclock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(GRID_DIM); i++) begin
        r_bitmap[i] <= '0;
      end
    end else if (bus.clear) begin
      for (int i = 0; i < int'(GRID_DIM); i++) begin
        r_bitmap[i] <= '0;
      end
    end else if (w_accept && w_is_origin) begin
      r_bitmap[w_row][~w_col] <= (bus.colour == FG_COLOUR);
    end
  end

  always_ff @(posedge fastclock or negedge resetn) begin
    if (!resetn) begin
      r_cnt        <= '0;
      r_frame_done <= 1'b0;
      r_oob_err    <= 1'b0;
    end else if (bus.clear) begin
      r_cnt        <= '0;
      r_frame_done <= 1'b0;
      r_oob_err    <= 1'b0;
    end else begin
      r_frame_done <= w_accept && (r_cnt == LAST_PLOT);
      if (w_accept) begin
        r_cnt <= (r_cnt == LAST_PLOT) ? 14'd0 : r_cnt + 14'd1;
      end
      if (bus.plot && !w_in_range) begin
        r_oob_err <= 1'b1;
      end
    end
  end

  // Reads see the bitmap as it stood before this edge, including across a clear.
  always_ff @(posedge fastclock or negedge resetn) begin
    if (!resetn) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= bus.rd_req;
      if (bus.rd_req) begin
        r_rd_data <= r_bitmap[bus.rd_row];
      end
    end
  end

  assign bus.rd_valid   = r_rd_valid;
  assign bus.rd_data    = r_rd_data;
  assign bus.frame_done = r_frame_done;
  assign bus.oob_err    = r_oob_err;

endmodule
